// File: rtl/gf2_polydiv_127by64.sv
`default_nettype none
// ============================================================================
// Module   : gf2_polydiv_127by64
// Purpose  : Sequential GF(2) polynomial divider. It divides a (2*W-1)-bit
//            carry-less product word by a monic W-bit divisor. It resolves one
//            quotient bit per cycle, from the top bit down. A result is
//            presented W clock edges after the operands are accepted.
//
// Ports    : clk       - single clock, rising edge
//            rst_n     - synchronous reset, active low
//            in_valid  - operand pair valid
//            in_ready  - block is idle and can accept operands
//            dividend  - (2*W-1)-bit polynomial, bit i = coeff of x^i
//            divisor   - W-bit polynomial, must have bit W-1 set
//            out_valid - result valid (held until out_ready)
//            out_ready - downstream accepts the result
//            quot      - W-bit quotient
//            rem       - (W-1)-bit remainder
//            div_err   - divisor bit W-1 was clear; quot/rem forced to 0
//
// Revision : 1.0 - initial release
// ============================================================================
module gf2_polydiv_127by64 #(
    parameter int W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-2:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quot,
    output logic [W-2:0]     rem,
    output logic             div_err
);

    localparam int DW = 2 * W - 1;
    localparam int CW = $clog2(W);
    localparam int IW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_work;
    logic [W-1:0]  r_div;
    logic [W-1:0]  r_qacc;
    logic [W-1:0]  r_quot;
    logic [W-2:0]  r_rem;
    logic          r_err;

    logic [IW-1:0] w_top_idx;
    logic          w_top;
    logic [DW-1:0] w_div_shl;
    logic [DW-1:0] w_work_nxt;
    logic [W-1:0]  w_qacc_nxt;
    logic          w_unused_hi;

    // Quotient bit i is decided by working bit (W-1+i). The divisor is monic
    // of degree W-1, so when that bit is set, XORing divisor<<i clears it.
    // Bits above it were already cleared by earlier iterations.
    always_comb begin
        w_top_idx  = IW'(W - 1) + IW'(r_cnt);
        w_top      = r_work[w_top_idx];
        w_div_shl  = {{(W-1){1'b0}}, r_div} << r_cnt;
        w_work_nxt = w_top ? (r_work ^ w_div_shl) : r_work;
        w_qacc_nxt = w_top ? (r_qacc | (W'(1) << r_cnt)) : r_qacc;
    end

    // After the last iteration the upper bits are all zero by construction;
    // only the low W-1 bits form the remainder.
    assign w_unused_hi = ^w_work_nxt[DW-1:W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_div   <= '0;
            r_qacc  <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (divisor[W-1]) begin
                            r_work  <= dividend;
                            r_div   <= divisor;
                            r_qacc  <= '0;
                            r_cnt   <= CW'(W - 1);
                            r_state <= S_CALC;
                        end else begin
                            // Non-monic divisor: report an error at once
                            // instead of running a meaningless division.
                            r_quot  <= '0;
                            r_rem   <= '0;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_CALC: begin
                    r_work <= w_work_nxt;
                    r_qacc <= w_qacc_nxt;
                    if (r_cnt == '0) begin
                        // Results are loaded only here, so they stay stable
                        // while the next operation is being computed.
                        r_quot  <= w_qacc_nxt;
                        r_rem   <= w_work_nxt[W-2:0];
                        r_err   <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign quot      = r_quot;
    assign rem       = r_rem;
    assign div_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gf2_polydiv_127by64.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf2_polydiv_127by64
// Purpose  : Self-checking bench for gf2_polydiv_127by64 (W=64). It runs
//            directed cases, backpressure, mid-operation reset and randomized
//            a*b^r operations. Expected results are queued at stimulus time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf2_polydiv_127by64;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [126:0]  dividend;
    logic [63:0]   divisor;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   quot;
    logic [62:0]   rem;
    logic          div_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] q;
        logic [62:0] r;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];

    gf2_polydiv_127by64 #(.W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_err   (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [126:0] clmul(input logic [63:0] a, input logic [63:0] b);
        logic [126:0] p;
        p = '0;
        for (int i = 0; i < 64; i++) begin
            if (b[i]) p = p ^ ({63'b0, a} << i);
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic junk_inputs();
        logic [127:0] j;
        j = {$urandom, $urandom, $urandom, $urandom};
        dividend = j[126:0];
        divisor  = j[63:0];
    endtask

    // Drive operands and complete the accepting edge; queue the expectation.
    task automatic start_op(input logic [126:0] dvd, input logic [63:0] dvs,
                            input logic [63:0] eq, input logic [62:0] er,
                            input logic ee, input int lat);
        exp_t e;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        e.q = eq; e.r = er; e.e = ee; e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        junk_inputs();
    endtask

    task automatic wait_valid(output int lat, output bit stable);
        logic [63:0] q0;
        logic [62:0] r0;
        q0 = quot;
        r0 = rem;
        stable = 1'b1;
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid === 1'b1) break;
            if (quot !== q0 || rem !== r0) stable = 1'b0;
            if (in_ready !== 1'b0) stable = 1'b0;
            if (lat > 200) break;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input bit stable);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, " sb_empty"}, 128'd1, 128'd0);
        end else begin
            e = sb.pop_front();
            check({tag, " latency"}, 128'(lat), 128'(e.lat));
            check({tag, " quot"}, {64'b0, quot}, {64'b0, e.q});
            check({tag, " rem"}, {65'b0, rem}, {65'b0, e.r});
            check({tag, " div_err"}, {127'b0, div_err}, {127'b0, e.e});
            check({tag, " calc_stable"}, {127'b0, stable}, 128'd1);
        end
    endtask

    task automatic release_done(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " idle_after"}, {126'b0, in_ready, out_valid}, 128'b10);
    endtask

    task automatic finish_op(input string tag);
        int lat;
        bit stable;
        wait_valid(lat, stable);
        check_result(tag, lat, stable);
        release_done(tag);
    endtask

    localparam logic [126:0] C_PROD = 127'h1_8000_0000_0000_0003;
    localparam logic [63:0]  C_DIV1 = 64'h8000_0000_0000_0001;
    localparam logic [63:0]  C_X63  = 64'h8000_0000_0000_0000;

    initial begin
        int lat;
        bit stable;
        logic [63:0] a, b, rr;
        logic [63:0] hq;
        logic [62:0] hr;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {127'b0, in_ready}, 128'd1);
        check("reset out_valid", {127'b0, out_valid}, 128'd0);
        check("reset outputs", {quot, rem, div_err}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_op(C_PROD, C_DIV1, 64'h3, 63'h0, 1'b0, 64);
        finish_op("inverse");

        start_op(127'h5, C_X63, 64'h0, 63'h5, 1'b0, 64);
        finish_op("small");

        start_op({127{1'b1}}, C_X63, 64'hFFFF_FFFF_FFFF_FFFF, 63'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64);
        finish_op("fullwidth");

        start_op(C_PROD, 64'h1, 64'h0, 63'h0, 1'b1, 1);
        finish_op("baddiv");

        start_op(C_PROD, 64'h0, 64'h0, 63'h0, 1'b1, 1);
        finish_op("zerodiv");

        // out_ready held high during CALC must not shorten latency.
        @(negedge clk);
        out_ready = 1'b1;
        start_op(127'h5, C_X63, 64'h0, 63'h5, 1'b0, 64);
        out_ready = 1'b1;
        wait_valid(lat, stable);
        check_result("rdy_high", lat, stable);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("rdy_high idle", {126'b0, in_ready, out_valid}, 128'b10);

        // Backpressure: hold result for 10 cycles while in_valid is high.
        start_op({127{1'b1}}, C_X63, 64'hFFFF_FFFF_FFFF_FFFF, 63'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64);
        wait_valid(lat, stable);
        check_result("bp", lat, stable);
        hq = quot; hr = rem;
        @(negedge clk);
        dividend = C_PROD; divisor = C_DIV1; in_valid = 1'b1;
        begin
            bit held;
            held = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== hq || rem !== hr || div_err !== 1'b0)
                    held = 1'b0;
            end
            check("bp held", {127'b0, held}, 128'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp idle", {126'b0, in_ready, out_valid}, 128'b10);
        begin
            exp_t e;
            e.q = 64'h3; e.r = 63'h0; e.e = 1'b0; e.lat = 64;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        junk_inputs();
        check("bp accepted", {127'b0, in_ready}, 128'd0);
        finish_op("bp_next");

        // Reset at counter 30 (33 CALC edges after accept), with in_valid high.
        start_op(C_PROD, C_DIV1, 64'h3, 63'h0, 1'b0, 64);
        repeat (33) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b1;
        dividend = C_PROD; divisor = C_DIV1;
        void'(sb.pop_front());
        @(posedge clk);
        #1;
        check("midrst state", {126'b0, in_ready, out_valid}, 128'b10);
        check("midrst outputs", {quot, rem, div_err}, 128'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst no_accept", {127'b0, in_ready}, 128'd1);
        start_op(C_PROD, C_DIV1, 64'h3, 63'h0, 1'b0, 64);
        finish_op("after_rst");

        // Randomized a*b ^ r operations.
        for (int n = 0; n < 1000; n++) begin
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            b[63] = 1'b1;
            rr = {$urandom, $urandom};
            start_op(clmul(a, b) ^ {64'b0, rr[62:0]}, b, a, rr[62:0], 1'b0, 64);
            finish_op("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
